truth_table_sweep_ctrl: RTL and testbench

//  Sequencer that characterises one 3-input combinational gate (e.g. a 0x6E case-table gate).

---
 rtl/tts_pkg.sv | 19 +
 rtl/tts_settle_timer.sv | 38 +++
 rtl/truth_table_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_truth_table_sweep_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
// Optional majority-vote sampling is enabled by defining TTS_MAJORITY_EN.
package tts_pkg;

    typedef enum logic [1:0] {
        TTS_IDLE   = 2'd0,
        TTS_SETTLE = 2'd1,
        TTS_FINISH = 2'd2
    } tts_state_e;

    localparam int TTS_ROWS  = 8;
    localparam int TTS_ROW_W = 3;

    // Row 000 lands in bit 7, row 111 in bit 0.
    function automatic logic [TTS_ROW_W-1:0] row_bit(input logic [TTS_ROW_W-1:0] row);
        return TTS_ROW_W'(TTS_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Per-row settle counter: counts while run is high, flags the final settle cycle and,
// with TTS_MAJORITY_EN, strobes the last three cycles for voting.
module tts_settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
`ifdef TTS_MAJORITY_EN
    output logic samp,
`endif
    output logic last
);

    logic [CNT_W-1:0] count_q, count_d;

    assign last = run && (count_q == CNT_W'(SETTLE_CYCLES - 1));

`ifdef TTS_MAJORITY_EN
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 3 when majority sampling is enabled");
    end
    assign samp = run && (count_q >= CNT_W'(SETTLE_CYCLES - 3));
`endif

    // Counter restarts on the sampling cycle so the next row gets a full window.
    always_comb begin
        count_d = '0;
        if (run && !last) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps a 3-input gate through all 8 rows, captures its truth-table code and compares it
// with a latched expected code. TTS_MAJORITY_EN selects 3-sample majority capture per row.
import tts_pkg::*;

module truth_table_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [7:0] mismatch
);

    tts_state_e           state_q;
    logic [TTS_ROW_W-1:0] row_q;
    logic [TTS_ROW_W-1:0] ins_q;
    logic                 busy_q, done_q, pass_q;
    logic [7:0]           table_q, table_d, mism_q, exp_q;
    logic                 last, smp_bit;

`ifdef TTS_MAJORITY_EN
    logic       samp;
    logic [1:0] vote_q;

    tts_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == TTS_SETTLE),
        .samp (samp),
        .last (last)
    );

    // Holds the two earlier samples of the window; the third is the live input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               vote_q <= 2'b00;
        else if (samp && !last) vote_q <= {vote_q[0], dut_out};
    end

    assign smp_bit = (vote_q[1] & vote_q[0]) | (vote_q[1] & dut_out) | (vote_q[0] & dut_out);
`else
    tts_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == TTS_SETTLE),
        .last (last)
    );

    assign smp_bit = dut_out;
`endif

    always_comb begin
        table_d = table_q;
        if (state_q == TTS_SETTLE && last) table_d[row_bit(row_q)] = smp_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TTS_IDLE;
            row_q   <= '0;
            ins_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= 8'h00;
            pass_q  <= 1'b0;
            mism_q  <= 8'h00;
            exp_q   <= 8'h00;
        end else begin
            case (state_q)
                TTS_IDLE: begin
                    done_q <= 1'b0;
                    ins_q  <= '0;
                    if (start) begin
                        exp_q   <= expected;
                        table_q <= 8'h00;
                        pass_q  <= 1'b0;
                        mism_q  <= 8'h00;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= TTS_SETTLE;
                    end
                end
                TTS_SETTLE: begin
                    if (last) begin
                        table_q <= table_d;
                        if (row_q == TTS_ROW_W'(TTS_ROWS - 1)) begin
                            done_q  <= 1'b1;
                            pass_q  <= (table_d == exp_q);
                            mism_q  <= table_d ^ exp_q;
                            ins_q   <= '0;
                            state_q <= TTS_FINISH;
                        end else begin
                            row_q <= row_q + 1'b1;
                            ins_q <= row_q + 1'b1;
                        end
                    end
                end
                TTS_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    row_q   <= '0;
                    state_q <= TTS_IDLE;
                end
                default: state_q <= TTS_IDLE;
            endcase
        end
    end

    assign {in1, in2, in3} = ins_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign pass      = pass_q;
    assign mismatch  = mism_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Bench for truth_table_sweep_ctrl: behavioural gate plus a table-level reference model.
module tb_truth_table_sweep_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, start, dut_out;
    logic [7:0] expected;
    logic       in1, in2, in3, busy, done, pass;
    logic [7:0] table_out, mismatch;

    logic [7:0] gate_code;
    bit         force_one, glitch;

    int n_chk = 0, n_pass = 0;
    int obs_done_cyc, obs_ndone, seq_err, busy_err;

    truth_table_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .table_out(table_out), .pass(pass), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    assign dut_out = (force_one ? 1'b1 : gate_code[3'd7 - {in1, in2, in3}]) ^ glitch;

    // Expected captured code: the gate's code, with a one-cycle glitch flipping its row's bit
    // only when it hits the single sampling cycle (majority voting rejects any single glitch).
    function automatic logic [7:0] model_table(input logic [7:0] g, input bit one, input int gc);
        logic [7:0] t;
        int row, cnt;
        t = one ? 8'hFF : g;
        if (gc > 0) begin
            row = (gc - 1) / S;
            cnt = (gc - 1) % S;
`ifndef TTS_MAJORITY_EN
            if (cnt == S - 1) t[7 - row] = ~t[7 - row];
`endif
        end
        return t;
    endfunction

    // Drives one sweep; cycle c is the c-th cycle after the start-accept edge.
    task automatic sweep(input logic [7:0] exp_v, input logic [7:0] exp_late,
                         input int glitch_c, input int s1, input int s2);
        logic [2:0] want_in;
        bit         want_busy;
        @(negedge clk); start = 1'b1; expected = exp_v;
        @(negedge clk); start = 1'b0;
        obs_done_cyc = -1; obs_ndone = 0; seq_err = 0; busy_err = 0;
        for (int c = 1; c <= 8*S + 2; c++) begin
            want_in   = (c <= 8*S) ? 3'((c - 1) / S) : 3'd0;
            want_busy = (c <= 8*S + 1);
            if ({in1, in2, in3} !== want_in) seq_err++;
            if (busy !== want_busy) busy_err++;
            if (done === 1'b1) begin
                obs_ndone++;
                if (obs_done_cyc < 0) obs_done_cyc = c;
            end
            glitch = (c == glitch_c);
            start  = (c == s1) || (c == s2);
            if (c == 2) expected = exp_late;
            @(negedge clk);
        end
        glitch = 1'b0; start = 1'b0;
    endtask

    task automatic check_sweep(input string nm, input logic [7:0] w_tab, input logic [7:0] w_exp);
        n_chk++; if (obs_done_cyc !== 8*S + 1) $display("FAIL %s done_cycle got %0d want %0d", nm, obs_done_cyc, 8*S + 1); else n_pass++;
        n_chk++; if (obs_ndone !== 1) $display("FAIL %s done_count got %0d want 1", nm, obs_ndone); else n_pass++;
        n_chk++; if (seq_err !== 0) $display("FAIL %s row_sequence errors got %0d want 0", nm, seq_err); else n_pass++;
        n_chk++; if (busy_err !== 0) $display("FAIL %s busy errors got %0d want 0", nm, busy_err); else n_pass++;
        n_chk++; if (table_out !== w_tab) $display("FAIL %s table_out got %h want %h", nm, table_out, w_tab); else n_pass++;
        n_chk++; if (pass !== (w_tab == w_exp)) $display("FAIL %s pass got %b want %b", nm, pass, w_tab == w_exp); else n_pass++;
        n_chk++; if (mismatch !== (w_tab ^ w_exp)) $display("FAIL %s mismatch got %h want %h", nm, mismatch, w_tab ^ w_exp); else n_pass++;
        n_chk++; if ({in1, in2, in3} !== 3'b000) $display("FAIL %s idle_inputs got %b want 000", nm, {in1, in2, in3}); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; expected = 8'h00;
        gate_code = 8'h6E; force_one = 1'b0; glitch = 1'b0;
        #12;
        n_chk++; if ({busy, done, pass} !== 3'b000) $display("FAIL reset flags got %b want 000", {busy, done, pass}); else n_pass++;
        n_chk++; if ({in1, in2, in3} !== 3'b000) $display("FAIL reset inputs got %b want 000", {in1, in2, in3}); else n_pass++;
        n_chk++; if (table_out !== 8'h00) $display("FAIL reset table_out got %h want 00", table_out); else n_pass++;
        n_chk++; if (mismatch !== 8'h00) $display("FAIL reset mismatch got %h want 00", mismatch); else n_pass++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        gate_code = 8'h6E;
        sweep(8'h6E, 8'h6E, 0, 0, 0);
        check_sweep("basic", model_table(8'h6E, 0, 0), 8'h6E);
    endtask

    task automatic test_mismatch();
        sweep(8'h6F, 8'h6F, 0, 0, 0);
        check_sweep("mismatch", model_table(8'h6E, 0, 0), 8'h6F);
    endtask

    task automatic test_ignored_start();
        sweep(8'h6E, 8'h6E, 0, 5, 8*S + 1);
        check_sweep("ignored_start", model_table(8'h6E, 0, 0), 8'h6E);
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL ignored_start no_retrigger busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_abort();
        int ndone;
        @(negedge clk); start = 1'b1; expected = 8'h6E;
        @(negedge clk); start = 1'b0;
        repeat (3*S) @(negedge clk);
        n_chk++; if ({in1, in2, in3} !== 3'd3) $display("FAIL abort pre_row got %0d want 3", {in1, in2, in3}); else n_pass++;
        rst = 1'b1; #1;
        n_chk++; if ({busy, done, pass} !== 3'b000) $display("FAIL abort flags got %b want 000", {busy, done, pass}); else n_pass++;
        n_chk++; if ({in1, in2, in3} !== 3'b000) $display("FAIL abort inputs got %b want 000", {in1, in2, in3}); else n_pass++;
        n_chk++; if (table_out !== 8'h00) $display("FAIL abort table_out got %h want 00", table_out); else n_pass++;
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10*S; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_chk++; if (ndone !== 0) $display("FAIL abort stray_done got %0d want 0", ndone); else n_pass++;
        sweep(8'h6E, 8'h6E, 0, 0, 0);
        check_sweep("after_abort", model_table(8'h6E, 0, 0), 8'h6E);
    endtask

    task automatic test_const_one();
        force_one = 1'b1;
        sweep(8'h00, 8'hFF, 0, 0, 0);
        check_sweep("const_one", model_table(8'h6E, 1, 0), 8'h00);
        force_one = 1'b0;
    endtask

    task automatic test_glitch();
        // Row 2, last settle cycle.
        sweep(8'h6E, 8'h6E, 2*S + S, 0, 0);
        check_sweep("glitch", model_table(8'h6E, 0, 2*S + S), 8'h6E);
`ifdef TTS_MAJORITY_EN
        n_chk++; if (table_out !== 8'h6E) $display("FAIL glitch_literal table_out got %h want 6E", table_out); else n_pass++;
`else
        n_chk++; if (table_out !== 8'h4E) $display("FAIL glitch_literal table_out got %h want 4E", table_out); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [7:0] g, e;
        int gc;
        for (int i = 0; i < 8; i++) begin
            g  = 8'($urandom);
            e  = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
            gc = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8*S));
            gate_code = g;
            sweep(e, 8'($urandom), gc, 0, 0);
            check_sweep($sformatf("random%0d", i), model_table(g, 0, gc), e);
        end
        gate_code = 8'h6E;
    endtask

    task automatic test_back_to_back();
        int c, d1, d2;
        d1 = -1; d2 = -1;
        @(negedge clk); start = 1'b1; expected = 8'h6E;
        for (c = 0; c < 4*(8*S + 2) && d2 < 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c; else d2 = c;
            end
        end
        start = 1'b0;
        n_chk++; if (d1 < 0 || d2 < 0) $display("FAIL back_to_back dones got %0d,%0d want two", d1, d2); else n_pass++;
        n_chk++; if (d2 - d1 !== 8*S + 2) $display("FAIL back_to_back spacing got %0d want %0d", d2 - d1, 8*S + 2); else n_pass++;
        n_chk++; if (table_out !== 8'h6E) $display("FAIL back_to_back table_out got %h want 6E", table_out); else n_pass++;
        repeat (8*S + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_ignored_start();
        test_abort();
        test_const_one();
        test_glitch();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
